// File: rtl/multicycle_data_memory_if.sv
// ----------------------------------------------------------------------------
// multicycle_data_memory_if
//   Request/response bundle between the memory stage (master) and the
//   multi-cycle data memory (slave).
//
//   Handshake semantics:
//     A request transfers on a rising clock edge where req_valid=1 and
//     req_ready=1. The master holds req_valid and the request fields stable
//     until that edge and may change them freely afterwards. rsp_valid is a
//     single-cycle pulse with no back-pressure; rsp_rdata is meaningful while
//     rsp_valid=1. busy flags a request in flight so the pipeline can stall.
//
//   Signals:
//     req_valid  master->slave  request present
//     req_wr     master->slave  1 = write, 0 = read
//     req_addr   master->slave  byte address
//     req_wdata  master->slave  write data
//     req_ready  slave->master  slave can accept a request this cycle
//     rsp_valid  slave->master  request completed (one-cycle pulse)
//     rsp_rdata  slave->master  read data (0 for writes)
//     busy       slave->master  request in flight
// ----------------------------------------------------------------------------
interface multicycle_data_memory_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/multicycle_data_memory.sv
// ----------------------------------------------------------------------------
// multicycle_data_memory
//   Responder for the pipeline data-memory port. One read or write is
//   accepted at a time and completed LATENCY cycles after the accept cycle,
//   signalled by a one-cycle rsp_valid pulse. A new request may be accepted
//   in the completion cycle, giving one request per LATENCY cycles.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     mem_bus      request/response bundle (slave side)
//     o_dbg_state  current FSM state (IDLE=0, WAIT=1, DONE=2)
//
//   Word index is req_addr[log2(DEPTH):1]; bit 0 and the upper bits are
//   ignored, so addresses alias modulo 2*DEPTH bytes. The array is not reset.
// ----------------------------------------------------------------------------
module multicycle_data_memory #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_data_memory_if.slave       mem_bus,
  output logic [1:0]                    o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;

  logic               r_wr;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_ready;
  logic               w_accept;
  logic               w_enter_done;
  logic               w_unused_addr_bits;

  assign w_ready      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept     = mem_bus.req_valid && w_ready;
  // The last WAIT cycle is the one with the counter at 1; the array access
  // happens on the edge that leaves it.
  assign w_enter_done = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));

  // Address bits outside the word index are intentionally ignored.
  assign w_unused_addr_bits = ^{mem_bus.req_addr[0], mem_bus.req_addr[ADDR_W-1:IDX_W+1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
          w_next_cnt   = CNT_W'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        w_next_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
          w_next_cnt   = CNT_W'(LATENCY - 1);
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Request capture at the accept edge and response data at DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= mem_bus.req_wr;
        r_idx   <= mem_bus.req_addr[IDX_W:1];
        r_wdata <= mem_bus.req_wdata;
      end
      if (w_enter_done) begin
        r_rdata <= r_wr ? '0 : r_mem[r_idx];
      end
    end
  end

  // Storage array. Reset returns the FSM to IDLE, so an in-flight write
  // never reaches this edge and the array is left unchanged.
  always_ff @(posedge clk) begin
    if (w_enter_done && r_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign mem_bus.req_ready = w_ready;
  assign mem_bus.rsp_valid = (r_state == S_DONE);
  assign mem_bus.busy      = (r_state == S_WAIT);
  assign mem_bus.rsp_rdata = r_rdata;
  assign o_dbg_state       = r_state;

endmodule

// File: doc/multicycle_data_memory.md
Name: multicycle_data_memory

Overview:
- Responder side of the pipeline's data-memory interface.
- Accepts one read or write request at a time from the memory stage and services it after a fixed multi-cycle latency.
- Returns a one-cycle response pulse, and exposes a busy signal the pipeline uses to stall.
- Replaces the single-cycle data memory and sits between the EX/MEM register and the MEM/WB register.

Parameters:
- ADDR_W, 16, width of the byte address bus.
- DATA_W, 16, data word width.
- DEPTH, 1024, number of DATA_W words in the array; power of two.
- LATENCY, 4, cycles from the accept cycle to the response cycle; legal range ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_wr  input  1  1 = write, 0 = read; qualified by req_valid
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  write data
- req_ready  output  1  responder can accept a request this cycle
- rsp_valid  output  1  one-cycle pulse: request completed
- rsp_rdata  output  DATA_W  read data, valid while rsp_valid=1
- busy  output  1  request in flight; pipeline stall

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All state resets immediately on rst_n=0, independent of clk.
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, counter=0.
  - Array contents are not reset; they are undefined until written.
- Addressing: word index = req_addr[log2(DEPTH):1]. req_addr[0] is ignored (misaligned access reads or writes the containing word). Bits above log2(DEPTH) are ignored, so addresses alias modulo 2*DEPTH bytes.
- States: IDLE, WAIT, DONE.
- Handshake:
  - A request is accepted in cycle c when req_valid=1 and req_ready=1 at the rising edge ending c.
  - req_ready = (state==IDLE) || (state==DONE), combinational from state.
  - req_wr, req_addr and req_wdata are captured at the accept edge. The requester may change them afterwards.
- Transitions:
  - IDLE --accept--> WAIT, counter loaded with LATENCY-1.
  - WAIT: counter decrements each edge. At the edge where counter==1, go to DONE; WAIT therefore lasts LATENCY-1 cycles (c+1 .. c+LATENCY-1).
  - DONE lasts exactly one cycle (c+LATENCY). If a new request is accepted in DONE, go to WAIT (counter=LATENCY-1); otherwise go to IDLE.
- Array access happens at the edge entering DONE:
  - Write: array[idx] <= captured wdata; rsp_rdata <= 0.
  - Read: rsp_rdata <= array[idx].
  - A request accepted in DONE therefore observes the preceding write.
- Outputs:
  - rsp_valid=1 only in DONE.
  - busy=1 only in WAIT.
  - rsp_rdata holds its value until the next DONE entry or reset.
- Throughput: one request per LATENCY cycles, achieved when each request is accepted in the previous DONE.
- req_valid in WAIT is ignored: no capture, no extra response. The requester must hold req_valid until req_ready.
- Reset mid-operation (WAIT or DONE): return to IDLE. The in-flight write is discarded and the array is unchanged. No rsp_valid is produced for it.
- Exactly one rsp_valid pulse per accepted request; never a response without a prior accept.

Test Plan:
1. LATENCY=4: write req_addr=0x0010, req_wdata=0xBEEF accepted in cycle c -> busy=1 in c+1..c+3; rsp_valid=1 only in c+4 with rsp_rdata=0x0000; req_ready=0 in c+1..c+3.
2. Read req_addr=0x0010 accepted in cycle c -> rsp_valid=1 in c+4 with rsp_rdata=0xBEEF; rsp_rdata still 0xBEEF in c+5 with rsp_valid=0.
3. Back-to-back: write 0x0020=0x1234 accepted in cycle c, then a read of 0x0020 presented in the DONE cycle (c+4) -> the read is accepted in c+4, rsp_valid in c+8 with rsp_rdata=0x1234; no IDLE cycle in between.
4. req_valid held high continuously with a read of 0x0010 starting at cycle c -> accepts at c, c+4, c+8; exactly one rsp_valid per accept; the inputs are never re-sampled during WAIT.
5. Write 0x0030=0xAAAA completes. Then write 0x0030=0x5555 accepted, with rst_n pulsed low in c+2 -> all outputs go to reset values immediately; no rsp_valid; a later read of 0x0030 returns 0xAAAA.
6. DEPTH=1024: write 0x0810=0xC0DE, then read 0x0010 and read 0x0011 -> both return 0xC0DE (alias and ignored bit 0).
